// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// datapath select codes, ALU operations and condition codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Unlisted commands fall back to ADD so the datapath never sees an undefined op.
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        logic [2:0] op;
        case (cmd)
            CMD_ADD: op = ALU_ADD;
            CMD_SUB: op = ALU_SUB;
            CMD_AND: op = ALU_AND;
            CMD_ORR: op = ALU_ORR;
            CMD_EOR: op = ALU_EOR;
            CMD_CMP: op = ALU_SUB;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_cond_check.sv
// Combinational ARM condition-code evaluation against the stored {N,Z,C,V} flags.
module mc_cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[3];
    assign w_z = i_flags[2];
    assign w_c = i_flags[1];
    assign w_v = i_flags[0];

    // Condition decode; the 1111 encoding never executes.
    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = 1'b0;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_wait.sv
// Multicycle ARM-subset controller with memory wait handshake, bounded
// timeout into a sticky fault state, and a retired-instruction counter.
module mc_ctrl_wait
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 255,
    parameter int COND_SKIP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0]      Instr,
    input  logic [3:0]       ALUFlags,
    input  logic             MemReady,
    output logic [1:0]       RegSrc,
    output logic [1:0]       ImmSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUControl,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             B,
    output logic             MemReq,
    output logic             MemFault,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_flags;
    logic [15:0]      r_wcnt;
    logic [CNT_W-1:0] r_retired;
    logic             r_cond_ex;

    logic [3:0] w_cond, w_cmd, w_rd;
    logic [1:0] w_op, w_flag_w;
    logic [5:0] w_funct;
    logic       w_cond_now, w_is_cmp, w_timeout, w_enter_mem, w_in_exe;
    logic       w_regw, w_memw, w_nextpc, w_b, w_pcs;
    logic       w_unused_rn;

    assign w_cond      = Instr[19:16];
    assign w_op        = Instr[15:14];
    assign w_funct     = Instr[13:8];
    assign w_cmd       = w_funct[4:1];
    assign w_rd        = Instr[3:0];
    assign w_unused_rn = ^Instr[7:4];

    assign w_is_cmp    = (w_cmd == CMD_CMP);
    assign w_flag_w[1] = w_funct[0] | w_is_cmp;
    assign w_flag_w[0] = (w_funct[0] & ((w_cmd == CMD_ADD) | (w_cmd == CMD_SUB))) | w_is_cmp;
    assign w_in_exe    = (r_state == S_EXER) || (r_state == S_EXEI);

    // The wait limit is hit on the cycle whose stall would bring the count to TIMEOUT.
    assign w_timeout   = ~MemReady && (r_wcnt == WAIT_LAST);
    assign w_enter_mem = (w_next_state != r_state) &&
                         ((w_next_state == S_FETCH) || (w_next_state == S_MEMRD) ||
                          (w_next_state == S_MEMWR));

    mc_cond_check u_cond_check (
        .i_cond    (w_cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_now)
    );

    // State register; CondEx is frozen at DECODE so a flag update in EXE cannot veto its own writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cond_ex <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            if (r_state == S_DECODE) begin
                r_cond_ex <= w_cond_now;
            end
        end
    end

    // Consecutive-wait counter for the memory handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt <= 16'd0;
        end else if (w_enter_mem) begin
            r_wcnt <= 16'd0;
        end else if (MemReq && !MemReady) begin
            r_wcnt <= r_wcnt + 16'd1;
        end
    end

    // Retired count: every return to FETCH closes one instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if ((w_next_state == S_FETCH) && (r_state != S_FETCH)) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Flag register, loaded from the ALU at the end of an executing data-processing op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_in_exe && r_cond_ex) begin
            if (w_flag_w[1]) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (w_flag_w[0]) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Next-state and ungated control decode.
    always_comb begin
        w_next_state = r_state;
        IRWrite      = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        ResultSrc    = RES_ALUOUT;
        ALUControl   = ALU_ADD;
        MemReq       = 1'b0;
        MemFault     = 1'b0;
        w_regw       = 1'b0;
        w_memw       = 1'b0;
        w_nextpc     = 1'b0;
        w_b          = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                MemReq    = 1'b1;
                if (MemReady) begin
                    IRWrite      = 1'b1;
                    w_nextpc     = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (!w_cond_now && (COND_SKIP != 0)) begin
                    w_next_state = S_FETCH;
                end else begin
                    case (w_op)
                        OP_MEM:  w_next_state = S_MEMADR;
                        OP_DP:   w_next_state = w_funct[5] ? S_EXEI : S_EXER;
                        OP_BR:   w_next_state = S_BRANCH;
                        default: w_next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB      = SRCB_IMM;
                w_next_state = w_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                MemReq = 1'b1;
                if (MemReady) begin
                    w_next_state = S_MEMWB;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_MEMRD;
                end
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                w_regw       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemReq = 1'b1;
                w_memw = 1'b1;
                if (MemReady) begin
                    w_next_state = S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_EXER, S_EXEI: begin
                ALUSrcB      = (r_state == S_EXEI) ? SRCB_IMM : SRCB_REG;
                ALUControl   = alu_decode(w_cmd);
                w_next_state = w_is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                w_regw       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB      = SRCB_IMM;
                ResultSrc    = RES_ALURES;
                w_b          = 1'b1;
                w_next_state = S_FETCH;
            end
            S_FAULT: begin
                MemFault     = 1'b1;
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign w_pcs    = w_b | (w_regw & (w_rd == 4'hF));
    assign RegWrite = w_regw & r_cond_ex;
    assign MemWrite = w_memw & r_cond_ex;
    assign PCWrite  = w_nextpc | (w_pcs & r_cond_ex);
    assign B        = w_b;
    assign RegSrc   = {(w_op == OP_MEM), (w_op == OP_BR)};
    assign ImmSrc   = w_op;
    assign Retired  = r_retired;

endmodule

// File: tb/tb_mc_ctrl_wait.sv
// Randomized scoreboard bench: each instruction is expanded by a phase-level
// reference model into per-cycle stimulus and expected outputs for two DUTs
// (COND_SKIP=1 and COND_SKIP=0) and checked cycle by cycle.
module tb_mc_ctrl_wait;

    localparam int TO  = 4;
    localparam int N_A = 300;
    localparam int N_B = 250;
    localparam logic [3:0] CMDS [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010};
    localparam logic [2:0] ALUC [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b001};

    typedef struct packed {
        logic [19:0] instr;
        logic [3:0]  af;
        logic        rdy;
        logic        rst;
    } stim_t;

    typedef struct packed {
        logic       irw, memw, regw, pcw, adrsrc, b, memreq, fault, srca;
        logic [1:0] srcb, ressrc, regsrc, immsrc;
        logic [2:0] aluc;
        logic [7:0] retired;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s [2];
    logic [19:0] instr_s [2];
    logic [3:0]  aluf_s [2];
    logic        rdy_s [2];
    logic [1:0]  regsrc_s [2], immsrc_s [2], srcb_s [2], ressrc_s [2];
    logic [2:0]  aluc_s [2];
    logic        srca_s [2], irw_s [2], memw_s [2], regw_s [2], pcw_s [2];
    logic        adrsrc_s [2], b_s [2], memreq_s [2], fault_s [2];
    logic [7:0]  ret_s [2];

    stim_t      stq [2][$];
    exp_t       exq [2][$];
    logic [3:0] flags_m [2];
    logic [7:0] ret_m [2];
    bit         done [2];
    int         n_pass = 0;
    int         n_total = 0;

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t dflt(input logic [19:0] ins, input logic [7:0] r);
        exp_t x;
        x = '0;
        x.regsrc  = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
        x.immsrc  = ins[15:14];
        x.retired = r;
        return x;
    endfunction

    function automatic int pick_wait(input bit allow_fault);
        int r;
        r = $urandom_range(0, 15);
        if (r < 8) return 0;
        if (r < 12) return $urandom_range(1, TO - 2);
        if (r < 14 || !allow_fault) return TO - 1;
        return $urandom_range(TO, TO + 2);
    endfunction

    task automatic add(input int d, input exp_t x, input logic rdy, input logic [19:0] ins,
                       input logic [3:0] af);
        stq[d].push_back('{instr: ins, af: af, rdy: rdy, rst: 1'b0});
        exq[d].push_back(x);
    endtask

    // A memory phase: w stalled cycles then one ready cycle, or TO stalls and a fault.
    task automatic mem_phase(input int d, input exp_t xw, input exp_t xr, input int w,
                             input logic [19:0] ins, output bit flt);
        flt = (w >= TO);
        for (int i = 0; i < (flt ? TO : w); i++) add(d, xw, 1'b0, ins, 4'($urandom));
        if (!flt) add(d, xr, 1'b1, ins, 4'($urandom));
    endtask

    task automatic plan_instr(input int d, input bit allow_fault);
        logic [3:0]  cond, rd, rn, ex_af;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [19:0] ins;
        logic [7:0]  r;
        exp_t        x, xr;
        stim_t       s;
        int          ci, sel, k;
        bit          ce, flt, is_cmp;
        sel   = $urandom_range(0, 9);
        op    = (sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
        cond  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        ci    = $urandom_range(0, 5);
        funct = (op == 2'b00) ? {1'($urandom_range(0, 1)), CMDS[ci], 1'($urandom_range(0, 1))}
                              : 6'($urandom_range(0, 63));
        rd    = 4'($urandom);
        rn    = 4'($urandom);
        ins   = {cond, op, funct, rn, rd};
        r      = ret_m[d];
        ce     = cond_ok(cond, flags_m[d]);
        is_cmp = (op == 2'b00) && (ci == 5);
        ex_af  = 4'($urandom);
        x = dflt(ins, r); x.srca = 1'b1; x.srcb = 2'b10; x.ressrc = 2'b10; x.memreq = 1'b1;
        xr = x; xr.irw = 1'b1; xr.pcw = 1'b1;
        mem_phase(d, x, xr, pick_wait(allow_fault), ins, flt);
        if (!flt) begin
            x = dflt(ins, r); x.srca = 1'b1; x.srcb = 2'b10; x.ressrc = 2'b10;
            add(d, x, 1'($urandom), ins, 4'($urandom));
            if (ce || d == 1) begin
                case (op)
                    2'b01: begin
                        x = dflt(ins, r); x.srcb = 2'b01;
                        add(d, x, 1'($urandom), ins, 4'($urandom));
                        x = dflt(ins, r); x.adrsrc = 1'b1; x.memreq = 1'b1; x.memw = ce && !funct[0];
                        mem_phase(d, x, x, pick_wait(allow_fault), ins, flt);
                        if (!flt && funct[0]) begin
                            x = dflt(ins, r); x.ressrc = 2'b01; x.regw = ce; x.pcw = ce && (rd == 4'hF);
                            add(d, x, 1'($urandom), ins, 4'($urandom));
                        end
                    end
                    2'b00: begin
                        x = dflt(ins, r); x.srcb = funct[5] ? 2'b01 : 2'b00; x.aluc = ALUC[ci];
                        add(d, x, 1'($urandom), ins, ex_af);
                        if (!is_cmp) begin
                            x = dflt(ins, r); x.regw = ce; x.pcw = ce && (rd == 4'hF);
                            add(d, x, 1'($urandom), ins, 4'($urandom));
                        end
                    end
                    2'b10: begin
                        x = dflt(ins, r); x.srcb = 2'b01; x.ressrc = 2'b10; x.b = 1'b1; x.pcw = ce;
                        add(d, x, 1'($urandom), ins, 4'($urandom));
                    end
                    default: ;
                endcase
            end
        end
        if (flt) begin
            x = dflt(ins, r); x.fault = 1'b1;
            for (int i = $urandom_range(0, 2); i >= 0; i--) add(d, x, 1'($urandom), ins, 4'($urandom));
            k = stq[d].size();
            s = stq[d][k-1]; s.rst = 1'b1; stq[d][k-1] = s;
            flags_m[d] = 4'h0;
            ret_m[d]   = 8'd0;
        end else if (allow_fault && $urandom_range(0, 15) == 0) begin
            k = $urandom_range(1, stq[d].size());
            while (stq[d].size() > k) begin
                void'(stq[d].pop_back());
                void'(exq[d].pop_back());
            end
            s = stq[d][k-1]; s.rst = 1'b1; stq[d][k-1] = s;
            flags_m[d] = 4'h0;
            ret_m[d]   = 8'd0;
        end else begin
            if (op == 2'b00 && ce) begin
                if (funct[0] || is_cmp) flags_m[d][3:2] = ex_af[3:2];
                if ((funct[0] && ci < 2) || is_cmp) flags_m[d][1:0] = ex_af[1:0];
            end
            ret_m[d] = r + 8'd1;
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_ctrl_wait #(
            .CNT_W     (8),
            .TIMEOUT   (TO),
            .COND_SKIP ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .reset      (rst_s[g]),
            .Instr      (instr_s[g]),
            .ALUFlags   (aluf_s[g]),
            .MemReady   (rdy_s[g]),
            .RegSrc     (regsrc_s[g]),
            .ImmSrc     (immsrc_s[g]),
            .ALUSrcA    (srca_s[g]),
            .ALUSrcB    (srcb_s[g]),
            .ResultSrc  (ressrc_s[g]),
            .ALUControl (aluc_s[g]),
            .IRWrite    (irw_s[g]),
            .MemWrite   (memw_s[g]),
            .RegWrite   (regw_s[g]),
            .PCWrite    (pcw_s[g]),
            .AdrSrc     (adrsrc_s[g]),
            .B          (b_s[g]),
            .MemReq     (memreq_s[g]),
            .MemFault   (fault_s[g]),
            .Retired    (ret_s[g])
        );

        initial begin : drv
            stim_t s;
            rst_s[g]   = 1'b1;
            instr_s[g] = 20'h0;
            aluf_s[g]  = 4'h0;
            rdy_s[g]   = 1'b0;
            flags_m[g] = 4'h0;
            ret_m[g]   = 8'd0;
            repeat (2) @(posedge clk);
            #1;
            for (int n = 0; n < N_A + N_B; n++) begin
                plan_instr(g, n >= N_A);
                while (stq[g].size() > 0) begin
                    s = stq[g].pop_front();
                    instr_s[g] = s.instr;
                    aluf_s[g]  = s.af;
                    rdy_s[g]   = s.rdy;
                    rst_s[g]   = s.rst;
                    @(posedge clk);
                    #1;
                end
            end
            done[g] = 1'b1;
        end

        initial begin : mon
            exp_t e, a;
            int   cyc;
            logic fw;
            cyc = 0;
            forever begin
                @(negedge clk);
                if (exq[g].size() > 0) begin
                    e = exq[g].pop_front();
                    a = '{irw: irw_s[g], memw: memw_s[g], regw: regw_s[g], pcw: pcw_s[g],
                          adrsrc: adrsrc_s[g], b: b_s[g], memreq: memreq_s[g], fault: fault_s[g],
                          srca: srca_s[g], srcb: srcb_s[g], ressrc: ressrc_s[g],
                          regsrc: regsrc_s[g], immsrc: immsrc_s[g], aluc: aluc_s[g],
                          retired: ret_s[g]};
                    n_total++;
                    if (a === e) begin
                        n_pass++;
                    end else begin
                        $display("FAIL dut%0d cycle %0d outputs (irw,memw,regw,pcw,adr,b,req,flt,srca,srcb,res,regsrc,imm,alu,ret): got %b expected %b",
                                 g, cyc, a, e);
                    end
                    fw = fault_s[g] & (irw_s[g] | memw_s[g] | regw_s[g] | pcw_s[g] | memreq_s[g]);
                    n_total++;
                    if (fw === 1'b0) begin
                        n_pass++;
                    end else begin
                        $display("FAIL dut%0d cycle %0d fault state drives enables: got %b expected 0",
                                 g, cyc, fw);
                    end
                    cyc++;
                end
            end
        end
    end

    initial begin
        fork
            wait (done[0] && done[1]);
            begin
                #2000000;
                $display("FAIL watchdog: stimulus did not complete (dut0 done=%0d dut1 done=%0d, expected both 1)",
                         done[0], done[1]);
                n_total++;
            end
        join_any
        disable fork;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
